// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the RV32I execute stage and a synchronous byte-enabled data memory.
// Optional address range fault (err 11) is enabled by defining LSU_RANGE_CHECK_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [1:0]        resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_byte_enable,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACCESS  = 2'b01,
        S_CAPTURE = 2'b10,
        S_ERR     = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
        end
        return ok;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = data[7:0];
            2'b01:   b = data[15:8];
            2'b10:   b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lane[1] ? data[31:16] : data[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = data;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              resp_valid_q, resp_valid_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] ea_s;
    logic              misaligned_s;
    logic              range_fault_s;
    logic [1:0]        req_err_s;

    // Request decode: effective address and error classification (illegal > misaligned > range)
    always_comb begin
        ea_s          = req_base + req_offset;
        misaligned_s  = ((req_funct3[1:0] == 2'b01) && ea_s[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (ea_s[1:0] != 2'b00));
        range_fault_s = RANGE_CHECK && (ea_s >= MEM_LIMIT);
        if (!f3_legal(req_is_store, req_funct3)) begin
            req_err_s = 2'b10;
        end else if (misaligned_s) begin
            req_err_s = 2'b01;
        end else if (range_fault_s) begin
            req_err_s = 2'b11;
        end else begin
            req_err_s = 2'b00;
        end
    end

    // Next-state and registered-output computation; strobes and responses default to idle
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        err_d        = err_q;
        mem_addr_d   = '0;
        mem_wdata_d  = 32'h0000_0000;
        mem_be_d     = 4'b0000;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 2'b00;
        resp_rdata_d = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    lane_d     = ea_s[1:0];
                    err_d      = req_err_s;
                    if (req_err_s != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_ACCESS;
                        mem_addr_d = ea_s;
                        if (req_is_store) begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = store_data(req_funct3, req_wdata);
                            mem_be_d    = store_be(req_funct3, ea_s[1:0]);
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (is_store_q) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_format(funct3_q, lane_q, mem_read_data);
            end
            S_ERR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            err_q        <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 2'b00;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_write       = mem_write_q;
    assign mem_read        = mem_read_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl: behavioural byte-enabled memory plus a response scoreboard.
// Honours LSU_RANGE_CHECK_EN for the out-of-range store case.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rd_r;
    logic        mem_clr;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_base        (req_base),
        .req_offset      (req_offset),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_byte_enable (mem_byte_enable),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_read_data   (mem_rd_r)
    );

    always #5 clk = ~clk;

    // Synchronous memory: byte-lane writes, registered read data
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem_rd_r <= 32'h0;
        end else begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byte_enable[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
            if (mem_read) mem_rd_r <= mem[mem_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd,
                          input logic [1:0] e_err, input logic [31:0] e_rd, input int e_lat,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
        int   lat;
        int   strobes;
        exp_t e;
        exp_t got;
        @(negedge clk);
        chk("ready_before", {31'b0, req_ready}, 32'd1);
        chk("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        e.err        = e_err;
        e.rdata      = e_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 1;
        strobes   = 0;
        while (1) begin
            @(negedge clk);
            chk("strobe_excl", {31'b0, mem_write & mem_read}, 32'd0);
            if (mem_write !== 1'b1) chk("be_no_write", {28'b0, mem_byte_enable}, 32'd0);
            if (mem_write === 1'b1 || mem_read === 1'b1) begin
                strobes++;
                chk("mem_write", {31'b0, mem_write}, {31'b0, st});
                chk("mem_read", {31'b0, mem_read}, {31'b0, ~st});
                chk("mem_addr", mem_addr, e_addr);
                if (st) begin
                    chk("mem_be", {28'b0, mem_byte_enable}, {28'b0, e_be});
                    chk("mem_wdata", mem_write_data, e_wd);
                end
            end
            if (resp_valid === 1'b1) break;
            if (lat >= 8) break;
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("strobe_count", 32'(strobes), (e_err == 2'b00) ? 32'd1 : 32'd0);
        if (resp_valid === 1'b1) begin
            chk("ready_at_resp", {31'b0, req_ready}, 32'd1);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                chk("resp_err", {30'b0, resp_err}, {30'b0, got.err});
                chk("resp_rdata", resp_rdata, got.rdata);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_clr      = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_base     = 32'h0;
        req_offset   = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {30'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_be", {28'b0, mem_byte_enable}, 32'd0);
        chk("rst_mem_wr_rd", {30'b0, mem_write, mem_read}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        rst_n   = 1'b1;
        mem_clr = 1'b0;

        //      st    f3      base          off           wdata         err    rdata         lat addr          be       wdata
        do_req(1'b1, 3'b000, 32'h100,      32'h3,        32'hA5,       2'b00, 32'h0,        2, 32'h103,      4'b1000, 32'hA5A5A5A5); // SB
        do_req(1'b0, 3'b000, 32'h100,      32'h3,        32'h0,        2'b00, 32'hFFFFFFA5, 3, 32'h103,      4'b0000, 32'h0);        // LB
        do_req(1'b0, 3'b100, 32'h100,      32'h3,        32'h0,        2'b00, 32'h000000A5, 3, 32'h103,      4'b0000, 32'h0);        // LBU
        do_req(1'b1, 3'b001, 32'h200,      32'h2,        32'h1234BEEF, 2'b00, 32'h0,        2, 32'h202,      4'b1100, 32'hBEEFBEEF); // SH
        do_req(1'b0, 3'b001, 32'h200,      32'h2,        32'h0,        2'b00, 32'hFFFFBEEF, 3, 32'h202,      4'b0000, 32'h0);        // LH
        do_req(1'b0, 3'b101, 32'h200,      32'h2,        32'h0,        2'b00, 32'h0000BEEF, 3, 32'h202,      4'b0000, 32'h0);        // LHU
        do_req(1'b0, 3'b010, 32'h100,      32'h5,        32'h0,        2'b01, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // LW misaligned
        do_req(1'b0, 3'b001, 32'h200,      32'h3,        32'h0,        2'b01, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // LH misaligned
        do_req(1'b0, 3'b011, 32'h100,      32'h0,        32'h0,        2'b10, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // illegal load
        do_req(1'b0, 3'b011, 32'h100,      32'h1,        32'h0,        2'b10, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // illegal beats misaligned
        do_req(1'b1, 3'b100, 32'h100,      32'h0,        32'h0,        2'b10, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // illegal store
        do_req(1'b1, 3'b010, 32'hFFFFFFFC, 32'h8,        32'hCAFEF00D, 2'b00, 32'h0,        2, 32'h4,        4'b1111, 32'hCAFEF00D); // SW wrap
        do_req(1'b0, 3'b010, 32'h0,        32'h4,        32'h0,        2'b00, 32'hCAFEF00D, 3, 32'h4,        4'b0000, 32'h0);        // LW
        do_req(1'b0, 3'b101, 32'h8,        32'hFFFFFFFE, 32'h0,        2'b00, 32'h0000CAFE, 3, 32'h6,        4'b0000, 32'h0);        // LHU neg offset
        do_req(1'b0, 3'b000, 32'h5,        32'h0,        32'h0,        2'b00, 32'hFFFFFFF0, 3, 32'h5,        4'b0000, 32'h0);        // LB lane 1
        do_req(1'b1, 3'b000, 32'h200,      32'h1,        32'h7E,       2'b00, 32'h0,        2, 32'h201,      4'b0010, 32'h7E7E7E7E); // SB lane 1
        do_req(1'b0, 3'b010, 32'h200,      32'h0,        32'h0,        2'b00, 32'hBEEF7E00, 3, 32'h200,      4'b0000, 32'h0);        // LW merged
`ifdef LSU_RANGE_CHECK_EN
        do_req(1'b1, 3'b010, 32'h1000,     32'h0,        32'h11223344, 2'b11, 32'h0,        2, 32'h0,        4'b0000, 32'h0);        // range fault
`else
        do_req(1'b1, 3'b010, 32'h1000,     32'h0,        32'h11223344, 2'b00, 32'h0,        2, 32'h1000,     4'b1111, 32'h11223344); // aliased store
`endif

        // Reset asserted at the edge that would leave CAPTURE: the load response is dropped
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_base     = 32'h100;
        req_offset   = 32'h3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_test_read", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_err", {30'b0, resp_err}, 32'd0);
        chk("midrst_mem", {mem_addr[27:0], mem_byte_enable}, 32'd0);
        chk("midrst_wr_rd", {30'b0, mem_write, mem_read}, 32'd0);
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;

        do_req(1'b0, 3'b100, 32'h100,      32'h3,        32'h0,        2'b00, 32'h000000A5, 3, 32'h103,      4'b0000, 32'h0);        // LBU after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
